// File: rtl/mem_bus_router_pkg.sv
// mem_bus_router_pkg: definitions shared by the memory bus router and its decoder.
//   state_t   - router FSM state encoding (IDLE, REQ, WAIT, DONE)
//   MAX_NREG  - largest supported region count
//   SEL_W     - width of a region index able to address MAX_NREG regions
//   slice_lo  - low bit of slice idx in a packed per-region vector of width w
package mem_bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int MAX_NREG = 8;
  localparam int SEL_W    = $clog2(MAX_NREG);

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_bus_router_dec.sv
// mem_bus_router_dec: combinational priority address decoder.
//   addr   in  AW     word address to decode
//   hit    out 1      address falls inside at least one region
//   idx    out SEL_W  lowest-numbered matching region
//   offset out AW     addr minus the base of the selected region
// Regions are inclusive [REG_BASE slice i .. REG_LIMIT slice i].
module mem_bus_router_dec
  import mem_bus_router_pkg::*;
#(
  parameter int                NREG      = 4,
  parameter int                AW        = 30,
  parameter logic [NREG*AW-1:0] REG_BASE  = '0,
  parameter logic [NREG*AW-1:0] REG_LIMIT = '0
) (
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [SEL_W-1:0] idx,
  output logic [AW-1:0]    offset
);

  // Walk from the highest index down so the lowest matching region is the
  // last one written and therefore wins.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (addr >= REG_BASE[slice_lo(i, AW) +: AW] &&
          addr <= REG_LIMIT[slice_lo(i, AW) +: AW]) begin
        hit    = 1'b1;
        idx    = SEL_W'(i);
        offset = addr - REG_BASE[slice_lo(i, AW) +: AW];
      end
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// mem_bus_router: routes one host transaction at a time to one of NREG
// address regions and returns a single-cycle response.
//   clk, rst           clock, asynchronous active-high reset
//   i_valid/o_ready    host request handshake (ready only in IDLE)
//   i_addr/i_data/i_wren/i_mask  host request fields
//   o_rvalid/o_rdata/o_rerr      host response (pulse, data, decode/timeout error)
//   o_dev_valid/i_dev_ready      per-region request handshake
//   o_dev_addr/o_dev_data/o_dev_wren/o_dev_mask  shared device request fields
//   i_dev_rvalid/i_dev_rdata     per-region response (rdata packed by region)
// Optional: define MEM_BUS_ROUTER_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT
// cycles with an error response.
module mem_bus_router
  import mem_bus_router_pkg::*;
#(
  parameter int                 NREG      = 4,
  parameter int                 AW        = 30,
  parameter int                 DW        = 32,
  parameter logic [NREG*AW-1:0] REG_BASE  = '0,
  parameter logic [NREG*AW-1:0] REG_LIMIT = '0,
  parameter int                 TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [AW-1:0]        i_addr,
  input  logic [DW-1:0]        i_data,
  input  logic                 i_wren,
  input  logic [DW/8-1:0]      i_mask,
  output logic                 o_rvalid,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_rerr,
  output logic [NREG-1:0]      o_dev_valid,
  input  logic [NREG-1:0]      i_dev_ready,
  output logic [AW-1:0]        o_dev_addr,
  output logic [DW-1:0]        o_dev_data,
  output logic                 o_dev_wren,
  output logic [DW/8-1:0]      o_dev_mask,
  input  logic [NREG-1:0]      i_dev_rvalid,
  input  logic [NREG*DW-1:0]   i_dev_rdata
);

  localparam int MW = DW / 8;

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [AW-1:0]    off_q;
  logic [DW-1:0]    data_q;
  logic             wren_q;
  logic [MW-1:0]    mask_q;
  logic [DW-1:0]    rdata_q;
  logic             rerr_q;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_idx;
  logic [AW-1:0]    dec_off;

  logic             dev_ready_sel;
  logic             dev_rvalid_sel;
  logic [DW-1:0]    dev_rdata_sel;
  logic             tmo;
  logic             in_req;

  mem_bus_router_dec #(
    .NREG      (NREG),
    .AW        (AW),
    .REG_BASE  (REG_BASE),
    .REG_LIMIT (REG_LIMIT)
  ) u_dec (
    .addr   (i_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_off)
  );

  // Pick out the selected region's handshake and data without indexing by a
  // register that may be wider than the region count.
  always_comb begin
    dev_ready_sel  = 1'b0;
    dev_rvalid_sel = 1'b0;
    dev_rdata_sel  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_q == SEL_W'(i)) begin
        dev_ready_sel  = i_dev_ready[i];
        dev_rvalid_sel = i_dev_rvalid[i];
        dev_rdata_sel  = i_dev_rdata[slice_lo(i, DW) +: DW];
      end
    end
  end

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_IDLE && i_valid) begin
      cnt <= '0;
    end else if (state == ST_REQ || state == ST_WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fire one cycle early so the error response lands TIMEOUT cycles after
  // accept, i.e. as the incremented count would reach TIMEOUT-1.
  assign tmo = (cnt == CNT_W'(TIMEOUT - 2));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      off_q   <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      mask_q  <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            sel_q  <= dec_idx;
            off_q  <= dec_off;
            data_q <= i_data;
            wren_q <= i_wren;
            mask_q <= i_mask;
            if (dec_hit) begin
              state <= ST_REQ;
            end else begin
              state   <= ST_DONE;
              rdata_q <= '0;
              rerr_q  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (dev_ready_sel) begin
            state <= ST_WAIT;
          end else if (tmo) begin
            state   <= ST_DONE;
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dev_rvalid_sel) begin
            state   <= ST_DONE;
            rdata_q <= dev_rdata_sel;
            rerr_q  <= 1'b0;
          end else if (tmo) begin
            state   <= ST_DONE;
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_req   = (state == ST_REQ);
  assign o_ready  = (state == ST_IDLE);
  assign o_rvalid = (state == ST_DONE);
  assign o_rdata  = rdata_q;
  assign o_rerr   = rerr_q;

  // Device fields are forced to zero outside REQ so idle devices never see
  // stale request data.
  always_comb begin
    o_dev_valid = '0;
    for (int i = 0; i < NREG; i++) begin
      o_dev_valid[i] = in_req && (sel_q == SEL_W'(i));
    end
  end

  assign o_dev_addr = in_req ? off_q  : '0;
  assign o_dev_data = in_req ? data_q : '0;
  assign o_dev_wren = in_req ? wren_q : 1'b0;
  assign o_dev_mask = in_req ? mask_q : '0;

endmodule

// File: tb/tb_mem_bus_router.sv
// tb_mem_bus_router: directed and randomized bench for mem_bus_router with
// two regions, plus a second instance with overlapping regions.
module tb_mem_bus_router;

  localparam int NREG = 2;
  localparam int AW   = 30;
  localparam int DW   = 32;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_data;
  logic            i_wren;
  logic [3:0]      i_mask;
  logic [1:0]      i_dev_ready;
  logic [1:0]      i_dev_rvalid;
  logic [63:0]     i_dev_rdata;

  logic            m_ready, m_rvalid, m_rerr, m_dev_wren;
  logic [DW-1:0]   m_rdata, m_dev_data;
  logic [1:0]      m_dev_valid;
  logic [AW-1:0]   m_dev_addr;
  logic [3:0]      m_dev_mask;

  logic            v_ready, v_rvalid, v_rerr, v_dev_wren;
  logic [DW-1:0]   v_rdata, v_dev_data;
  logic [1:0]      v_dev_valid;
  logic [AW-1:0]   v_dev_addr;
  logic [3:0]      v_dev_mask;

  mem_bus_router #(
    .NREG(NREG), .AW(AW), .DW(DW),
    .REG_BASE ({30'h100, 30'h000}),
    .REG_LIMIT({30'h1FF, 30'h0FF}),
    .TIMEOUT  (16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(m_ready),
    .i_addr(i_addr), .i_data(i_data), .i_wren(i_wren), .i_mask(i_mask),
    .o_rvalid(m_rvalid), .o_rdata(m_rdata), .o_rerr(m_rerr),
    .o_dev_valid(m_dev_valid), .i_dev_ready(i_dev_ready),
    .o_dev_addr(m_dev_addr), .o_dev_data(m_dev_data),
    .o_dev_wren(m_dev_wren), .o_dev_mask(m_dev_mask),
    .i_dev_rvalid(i_dev_rvalid), .i_dev_rdata(i_dev_rdata)
  );

  mem_bus_router #(
    .NREG(NREG), .AW(AW), .DW(DW),
    .REG_BASE ({30'h100, 30'h000}),
    .REG_LIMIT({30'h1FF, 30'h1FF}),
    .TIMEOUT  (16)
  ) u_ovl (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(v_ready),
    .i_addr(i_addr), .i_data(i_data), .i_wren(i_wren), .i_mask(i_mask),
    .o_rvalid(v_rvalid), .o_rdata(v_rdata), .o_rerr(v_rerr),
    .o_dev_valid(v_dev_valid), .i_dev_ready(i_dev_ready),
    .o_dev_addr(v_dev_addr), .o_dev_data(v_dev_data),
    .o_dev_wren(v_dev_wren), .o_dev_mask(v_dev_mask),
    .i_dev_rvalid(i_dev_rvalid), .i_dev_rdata(i_dev_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference region map for u_dut.
  int unsigned mbase [2] = '{32'h000, 32'h100};
  int unsigned mlim  [2] = '{32'h0FF, 32'h1FF};

  function automatic int find_region(input int unsigned a);
    for (int i = 0; i < 2; i++)
      if (a >= mbase[i] && a <= mlim[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full transaction on u_dut: the bench plays the device, holding ready
  // low for rdy_dly cycles and sending rv_dly spurious rvalids on the other
  // region before the real response.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [3:0] m,
                         input int rdy_dly, input int rv_dly,
                         input logic [DW-1:0] rd);
    int r;
    logic [AW-1:0] exp_off;
    logic [1:0] oh;
    r = find_region(int'(a));
    @(negedge clk);
    chk("ready_idle", m_ready, 1);
    i_valid = 1'b1; i_addr = a; i_data = d; i_wren = w; i_mask = m;
    @(posedge clk); #1;
    i_valid = 1'b0; i_addr = '0; i_data = '0; i_wren = 1'b0; i_mask = '0;
    if (r < 0) begin
      @(negedge clk);
      chk("miss_rvalid", m_rvalid, 1);
      chk("miss_rerr", m_rerr, 1);
      chk("miss_rdata", m_rdata, 0);
      chk("miss_devvalid", m_dev_valid, 0);
      @(negedge clk);
      chk("miss_after_rvalid", m_rvalid, 0);
      chk("miss_after_ready", m_ready, 1);
      chk("miss_hold_rerr", m_rerr, 1);
    end else begin
      oh = 2'(1 << r);
      exp_off = AW'(int'(a) - int'(mbase[r]));
      for (int k = 0; k <= rdy_dly; k++) begin
        @(negedge clk);
        chk("req_valid", m_dev_valid, oh);
        chk("req_addr", m_dev_addr, exp_off);
        chk("req_data", m_dev_data, d);
        chk("req_wren", m_dev_wren, w);
        chk("req_mask", m_dev_mask, m);
        chk("req_rvalid", m_rvalid, 0);
        if (k == rdy_dly) i_dev_ready = oh;
        @(posedge clk); #1;
        i_dev_ready = 2'b00;
      end
      for (int k = 0; k <= rv_dly; k++) begin
        @(negedge clk);
        chk("wait_devvalid", m_dev_valid, 0);
        chk("wait_devaddr", m_dev_addr, 0);
        chk("wait_rvalid", m_rvalid, 0);
        i_dev_rdata = {$urandom, $urandom};
        if (k < rv_dly) begin
          i_dev_rvalid = ~oh;
        end else begin
          i_dev_rvalid = oh;
          i_dev_rdata[r*DW +: DW] = rd;
        end
        @(posedge clk); #1;
        i_dev_rvalid = 2'b00;
        i_dev_rdata = '0;
      end
      @(negedge clk);
      chk("hit_rvalid", m_rvalid, 1);
      chk("hit_rdata", m_rdata, rd);
      chk("hit_rerr", m_rerr, 0);
      @(negedge clk);
      chk("hit_after_rvalid", m_rvalid, 0);
      chk("hit_after_ready", m_ready, 1);
      chk("hit_hold_rdata", m_rdata, rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_addr = '0; i_data = '0; i_wren = 1'b0; i_mask = '0;
    i_dev_ready = '0; i_dev_rvalid = '0; i_dev_rdata = '0;

    // Reset state
    #3;
    chk("rst_ready", m_ready, 1);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_rerr", m_rerr, 0);
    chk("rst_devvalid", m_dev_valid, 0);
    chk("rst_devaddr", m_dev_addr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Overlapping regions: lowest index wins on u_ovl
    @(negedge clk);
    i_valid = 1'b1; i_addr = 30'h150;
    @(posedge clk); #1;
    i_valid = 1'b0; i_addr = '0;
    @(negedge clk);
    chk("ovl_valid", v_dev_valid, 2'b01);
    chk("ovl_addr", v_dev_addr, 30'h150);
    chk("ovl_main_valid", m_dev_valid, 2'b10);
    chk("ovl_main_addr", m_dev_addr, 30'h050);
    i_dev_ready = 2'b11;
    @(posedge clk); #1;
    i_dev_ready = 2'b00;
    @(negedge clk);
    i_dev_rvalid = 2'b11; i_dev_rdata = {32'h2222_2222, 32'h1111_1111};
    @(posedge clk); #1;
    i_dev_rvalid = 2'b00; i_dev_rdata = '0;
    @(negedge clk);
    chk("ovl_rdata", v_rdata, 32'h1111_1111);
    chk("ovl_main_rdata", m_rdata, 32'h2222_2222);

    // Best-case read hit in region 1
    run_txn(30'h105, 32'h0, 1'b0, 4'hF, 0, 0, 32'hCAFE_F00D);
    // Miss
    run_txn(30'h300, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0);
    // Write with ready held low for 5 cycles
    run_txn(30'h010, 32'h1234_5678, 1'b1, 4'b0011, 5, 2, 32'hA5A5_0001);
    // Region edges
    run_txn(30'h0FF, 32'h1, 1'b0, 4'h1, 1, 1, 32'h0000_00FF);
    run_txn(30'h100, 32'h2, 1'b1, 4'h2, 0, 1, 32'h0000_0100);
    run_txn(30'h200, 32'h3, 1'b0, 4'h4, 0, 0, 32'h0);

    // Randomized transactions
    for (int n = 0; n < 16; n++) begin
      run_txn(AW'($urandom_range(0, 32'h2FF)), $urandom, 1'($urandom),
              4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while in REQ drops device valid at once
    @(negedge clk);
    i_valid = 1'b1; i_addr = 30'h105;
    @(posedge clk); #1;
    i_valid = 1'b0; i_addr = '0;
    @(negedge clk);
    chk("rreq_valid_before", m_dev_valid, 2'b10);
    rst = 1'b1; #1;
    chk("rreq_valid_after", m_dev_valid, 0);
    chk("rreq_ready", m_ready, 1);
    #1 rst = 1'b0;

    // Reset while in WAIT followed by a spurious response
    @(negedge clk);
    i_valid = 1'b1; i_addr = 30'h105;
    @(posedge clk); #1;
    i_valid = 1'b0; i_addr = '0;
    @(negedge clk);
    i_dev_ready = 2'b10;
    @(posedge clk); #1;
    i_dev_ready = 2'b00;
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rwait_ready", m_ready, 1);
    chk("rwait_rvalid", m_rvalid, 0);
    chk("rwait_rdata", m_rdata, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_dev_rvalid = 2'b10; i_dev_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
      chk("rwait_no_rvalid", m_rvalid, 0);
      chk("rwait_idle", m_ready, 1);
      chk("rwait_rerr", m_rerr, 0);
      chk("rwait_devvalid", m_dev_valid, 0);
    end
    @(negedge clk);
    i_dev_rvalid = 2'b00; i_dev_rdata = '0;
    chk("rwait_final_rvalid", m_rvalid, 0);
    chk("rwait_final_rdata", m_rdata, 0);

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    // Device never answers: error response 16 cycles after accept
    @(negedge clk);
    i_valid = 1'b1; i_addr = 30'h020;
    @(posedge clk); #1;
    i_valid = 1'b0; i_addr = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("tmo_pending", m_rvalid, 0);
    end
    @(negedge clk);
    chk("tmo_rvalid", m_rvalid, 1);
    chk("tmo_rerr", m_rerr, 1);
    chk("tmo_rdata", m_rdata, 0);
    chk("tmo_devvalid", m_dev_valid, 0);
    @(negedge clk);
    chk("tmo_ready", m_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_router.md
MEM_BUS_ROUTER -- requirements
Module: mem_bus_router

Interface
REQ-001 The module SHALL have parameter NREG, default 4, giving the number of target regions (1..8).
REQ-002 The module SHALL have parameter AW, default 30, giving the word address width.
REQ-003 The module SHALL have parameter DW, default 32, giving the data width; the mask width is DW/8.
REQ-004 The module SHALL have parameter REG_BASE, default 0 (NREG*AW bits packed), holding the inclusive start of each region; region i occupies slice i.
REQ-005 The module SHALL have parameter REG_LIMIT, default 0 (NREG*AW bits packed), holding the inclusive end of each region.
REQ-006 The module SHALL have parameter TIMEOUT, default 256, giving the maximum number of cycles in REQ+WAIT.
REQ-007 The module SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-008 The host request ports SHALL be: i_valid in 1; o_ready out 1; i_addr in AW; i_data in DW; i_wren in 1; i_mask in DW/8.
REQ-009 The host response ports SHALL be: o_rvalid out 1 (response pulse); o_rdata out DW; o_rerr out 1 (decode or timeout error).
REQ-010 The device request ports SHALL be: o_dev_valid out NREG; i_dev_ready in NREG; o_dev_addr out AW (shared); o_dev_data out DW; o_dev_wren out 1; o_dev_mask out DW/8.
REQ-011 The device response ports SHALL be: i_dev_rvalid in NREG; i_dev_rdata in NREG*DW (packed by region).

Function
REQ-012 The FSM SHALL have the states IDLE, REQ, WAIT and DONE; exactly one transaction is outstanding at a time.
REQ-013 In IDLE, o_ready SHALL be 1; in all other states it SHALL be 0.
REQ-014 On i_valid && o_ready, the block SHALL latch addr, data, wren and mask, then decode the address against REG_BASE <= addr <= REG_LIMIT.
REQ-015 If several regions match, the lowest index SHALL win.
REQ-016 On a hit, the FSM SHALL go to REQ with sel = the matching index; on a miss, it SHALL go to DONE with err=1 and rdata=0.
REQ-017 In REQ, o_dev_valid[sel] SHALL be 1 and all other bits 0; o_dev_addr SHALL equal addr - REG_BASE[sel], truncated to AW.
REQ-018 When not in REQ, o_dev_valid SHALL be 0, and o_dev_addr/data/wren/mask SHALL be 0; no X is driven.
REQ-019 In REQ, when i_dev_ready[sel]=1, the FSM SHALL go to WAIT.
REQ-020 In WAIT, when i_dev_rvalid[sel]=1, the block SHALL capture i_dev_rdata slice sel and go to DONE with err=0; this applies to writes as well as reads.
REQ-021 i_dev_rvalid on a non-selected index, or in any state other than WAIT, SHALL be ignored.
REQ-022 DONE SHALL last exactly one cycle: o_rvalid=1, with o_rdata/o_rerr registered; the next state is IDLE.
REQ-023 Outside DONE, o_rvalid SHALL be 0; o_rdata and o_rerr SHALL hold their last value.
REQ-024 The best-case hit latency SHALL be: accept at cycle T; REQ at T+1 (ready the same cycle); WAIT at T+2 (rvalid the same cycle); o_rvalid at T+3.
REQ-025 The miss latency SHALL be: accept at T; o_rvalid with o_rerr=1 at T+1.

Reset
REQ-026 On rst=1, asynchronously, the FSM SHALL be IDLE and all outputs and registers SHALL be 0, except o_ready, which SHALL be 1 once in IDLE.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response issued; device-side valid drops immediately.

Configuration
REQ-028 With MEM_BUS_ROUTER_TIMEOUT_EN defined, a counter SHALL clear on accept and increment each cycle in REQ or WAIT.
REQ-029 When that counter reaches TIMEOUT-1 without completion, the FSM SHALL go to DONE with err=1 and rdata=0, and o_dev_valid SHALL drop.
REQ-030 Without MEM_BUS_ROUTER_TIMEOUT_EN, there SHALL be no counter, and REQ/WAIT wait indefinitely.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the maximum region count (8) and region slice helper constants.
REQ-032 One sub-module, mem_bus_router_dec, SHALL implement combinational priority address decode to a hit flag, an index and an offset.

Verification
REQ-033 NREG=2, regions [0x000..0x0FF] and [0x100..0x1FF]; read at 0x105 -> o_dev_valid=2'b10, o_dev_addr=0x005; rdata 0xCAFEF00D -> o_rvalid at T+3, o_rdata=0xCAFEF00D, o_rerr=0.
REQ-034 Read at 0x300 -> no o_dev_valid; at T+1, o_rvalid=1, o_rerr=1, o_rdata=0.
REQ-035 Write 0x12345678 with mask 4'b0011 to 0x010 with i_dev_ready held low for 5 cycles -> o_dev_valid[0] held for 6 cycles with stable fields; o_rvalid follows rvalid.
REQ-036 Overlapping regions [0x000..0x1FF] and [0x100..0x1FF], access at 0x150 -> region 0 selected, offset 0x150.
REQ-037 With TIMEOUT_EN and TIMEOUT=16, the device never responds -> o_rvalid with o_rerr=1 at 16 cycles after accept, then o_ready=1.
REQ-038 rst asserted while in WAIT, with a spurious i_dev_rvalid afterward -> IDLE, no o_rvalid, outputs 0.
